// File: rtl/uart_tx_frame_pkg.sv
// Shared types and line-level constants for the UART transmit engine.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic PAR_EVEN    = 1'b0;
    localparam logic PAR_ODD     = 1'b1;
    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/uart_tx_frame_if.sv
// Host-side handshake and serial-line signals of the UART transmitter.
interface uart_tx_frame_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] p_data;
    logic                  data_valid;
    logic                  par_en;
    logic                  par_typ;
    logic                  stop2;
    logic                  TX_out;
    logic                  busy;
    logic                  done;

    modport master (
        output p_data, data_valid, par_en, par_typ, stop2,
        input  TX_out, busy, done
    );

    modport slave (
        input  p_data, data_valid, par_en, par_typ, stop2,
        output TX_out, busy, done
    );
endinterface

// File: rtl/uart_tx_frame_baud_tick.sv
// Bit-period prescaler: tick marks the last clk of every serial bit.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clear,
    output logic tick
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // With one clk per bit LAST is zero, so tick stays high while enabled.
    assign tick = en && (cnt_q == LAST);

    // Count 0..CLKS_PER_BIT-1 while a frame runs; restart on acceptance.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Prescale counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit engine: start, DATA_WIDTH bits LSB-first, optional parity,
// one or two stop bits. Frame settings are captured when a word is accepted.
module uart_tx_frame
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic            clk,
    input  logic            rst,
    uart_tx_frame_if.slave  bus
);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    tx_state_t             state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic                  par_en_q, par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic                  stop2_q, stop2_d;
    logic                  tx_q, tx_d;
    logic                  done_q, done_d;
    logic                  accept;
    logic                  tick;

    assign accept = (state_q == IDLE) && bus.data_valid;

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .en   (state_q != IDLE),
        .clear(accept),
        .tick (tick)
    );

    // Next-state and next-output logic; the data word is shifted out so
    // data_q[0] is always the next data bit to emit.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        bit_cnt_d = bit_cnt_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        stop2_d   = stop2_q;
        tx_d      = tx_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.data_valid) begin
                    state_d   = START;
                    data_d    = bus.p_data;
                    par_en_d  = bus.par_en;
                    par_bit_d = (^bus.p_data) ^ bus.par_typ;
                    stop2_d   = bus.stop2;
                    bit_cnt_d = '0;
                    tx_d      = START_LEVEL;
                end
            end
            START: begin
                if (tick) begin
                    state_d   = DATA;
                    tx_d      = data_q[0];
                    data_d    = data_q >> 1;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        if (par_en_q) begin
                            state_d = PARITY;
                            tx_d    = par_bit_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = IDLE_LEVEL;
                        end
                    end else begin
                        tx_d      = data_q[0];
                        data_d    = data_q >> 1;
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_d   = STOP;
                    tx_d      = IDLE_LEVEL;
                    bit_cnt_d = '0;
                end
            end
            STOP: begin
                if (tick) begin
                    if (stop2_q && (bit_cnt_q == '0)) begin
                        bit_cnt_d = BW'(1);
                    end else begin
                        state_d = IDLE;
                        tx_d    = IDLE_LEVEL;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = IDLE_LEVEL;
            end
        endcase
    end

    // State and frame registers; reset aborts any frame immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            data_q    <= '0;
            bit_cnt_q <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
            tx_q      <= IDLE_LEVEL;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            bit_cnt_q <= bit_cnt_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            stop2_q   <= stop2_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
        end
    end

    assign bus.TX_out = tx_q;
    assign bus.busy   = (state_q != IDLE);
    assign bus.done   = done_q;
endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: two instances (8 bits / 4 clk per bit,
// 7 bits / 1 clk per bit) driven with hand-computed frames.
module tb_uart_tx_frame;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    uart_tx_frame_if #(.DATA_WIDTH(8)) a_if ();
    uart_tx_frame_if #(.DATA_WIDTH(7)) b_if ();

    uart_tx_frame #(.DATA_WIDTH(8), .CLKS_PER_BIT(4)) dut_a (
        .clk(clk), .rst(rst), .bus(a_if.slave)
    );
    uart_tx_frame #(.DATA_WIDTH(7), .CLKS_PER_BIT(1)) dut_b (
        .clk(clk), .rst(rst), .bus(b_if.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a word on instance A; returns at the negedge after acceptance.
    task automatic start_a(input logic [7:0] d, input logic pe, input logic pt, input logic s2);
        a_if.p_data     = d;
        a_if.par_en     = pe;
        a_if.par_typ    = pt;
        a_if.stop2      = s2;
        a_if.data_valid = 1'b1;
        @(negedge clk);
    endtask

    // Follow one frame from the negedge after acceptance until busy drops.
    // exp lists the transmitted bits in order as '0'/'1' characters.
    task automatic run_frame(input string tag, input bit sel, input int cpb,
                             input string exp, input int chg_cyc);
        int n = exp.len();
        int cyc = 0;
        int idx;
        int hold_err = 0;
        int done_mid = 0;
        logic [15:0] got = '0;
        logic [15:0] want = '0;
        logic tx, bz, dn;
        for (int i = 0; i < n; i++) want[i] = (exp[i] == 8'h31);
        while (1) begin
            tx = sel ? b_if.TX_out : a_if.TX_out;
            bz = sel ? b_if.busy   : a_if.busy;
            dn = sel ? b_if.done   : a_if.done;
            if (!bz || cyc >= 300) break;
            idx = cyc / cpb;
            if (idx < n) begin
                if (tx !== want[idx]) hold_err++;
                if ((cyc % cpb) == (cpb / 2)) got[idx] = tx;
            end else begin
                hold_err++;
            end
            if (dn) done_mid++;
            if (cyc == chg_cyc) begin
                a_if.p_data  = 8'hFF;
                a_if.par_en  = 1'b1;
                a_if.par_typ = 1'b1;
                a_if.stop2   = 1'b1;
            end
            cyc++;
            @(negedge clk);
        end
        check({tag, "_len"}, 32'(cyc), 32'(n * cpb));
        check({tag, "_bits"}, {16'h0, got}, {16'h0, want});
        check({tag, "_hold"}, 32'(hold_err), 32'd0);
        check({tag, "_done_early"}, 32'(done_mid), 32'd0);
        check({tag, "_done"}, {31'h0, dn}, 32'd1);
        check({tag, "_idle_tx"}, {31'h0, tx}, 32'd1);
        $display("frame %s: %0d cycles, bits %0h (want %0h)", tag, cyc, got, want);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        a_if.p_data = '0; a_if.data_valid = 0; a_if.par_en = 0; a_if.par_typ = 0; a_if.stop2 = 0;
        b_if.p_data = '0; b_if.data_valid = 0; b_if.par_en = 0; b_if.par_typ = 0; b_if.stop2 = 0;
        #12;
        check("rst_tx_a", {31'h0, a_if.TX_out}, 32'd1);
        check("rst_busy_a", {31'h0, a_if.busy}, 32'd0);
        check("rst_done_a", {31'h0, a_if.done}, 32'd0);
        check("rst_tx_b", {31'h0, b_if.TX_out}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("idle_tx_a", {31'h0, a_if.TX_out}, 32'd1);

        // 0xA5, even parity, one stop
        start_a(8'hA5, 1'b1, 1'b0, 1'b0);
        a_if.data_valid = 1'b0;
        run_frame("even1", 1'b0, 4, "01010010101", -1);
        @(negedge clk);
        check("even1_done_drop", {31'h0, a_if.done}, 32'd0);

        // 0x00, odd parity, two stops
        start_a(8'h00, 1'b1, 1'b1, 1'b1);
        a_if.data_valid = 1'b0;
        run_frame("odd2", 1'b0, 4, "000000000111", -1);
        @(negedge clk);

        // 7-bit instance, one bit per clk, no parity
        b_if.p_data = 7'h7F;
        b_if.data_valid = 1'b1;
        @(negedge clk);
        b_if.data_valid = 1'b0;
        run_frame("fast7", 1'b1, 1, "011111111", -1);
        @(negedge clk);

        // back-to-back with data_valid held high
        start_a(8'h3C, 1'b0, 1'b0, 1'b0);
        a_if.p_data = 8'hC3;
        run_frame("b2b_first", 1'b0, 4, "0001111001", -1);
        check("b2b_gap_busy", {31'h0, a_if.busy}, 32'd0);
        @(negedge clk);
        check("b2b_second_busy", {31'h0, a_if.busy}, 32'd1);
        check("b2b_second_start", {31'h0, a_if.TX_out}, 32'd0);
        check("b2b_second_done", {31'h0, a_if.done}, 32'd0);
        a_if.data_valid = 1'b0;
        run_frame("b2b_second", 1'b0, 4, "0110000111", -1);
        @(negedge clk);
        check("b2b_no_dup", {31'h0, a_if.busy}, 32'd0);

        // configuration changed during DATA must not affect the frame
        start_a(8'h96, 1'b0, 1'b0, 1'b0);
        a_if.data_valid = 1'b0;
        run_frame("midcfg", 1'b0, 4, "0011010011", 8);
        a_if.p_data = '0; a_if.par_en = 0; a_if.par_typ = 0; a_if.stop2 = 0;
        @(negedge clk);

        // asynchronous reset during the third data bit
        start_a(8'hA5, 1'b0, 1'b0, 1'b0);
        a_if.data_valid = 1'b0;
        repeat (13) @(negedge clk);
        check("pre_rst_busy", {31'h0, a_if.busy}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_tx", {31'h0, a_if.TX_out}, 32'd1);
        check("async_rst_busy", {31'h0, a_if.busy}, 32'd0);
        check("async_rst_done", {31'h0, a_if.done}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_idle", {31'h0, a_if.busy}, 32'd0);
        start_a(8'h5A, 1'b1, 1'b1, 1'b0);
        a_if.data_valid = 1'b0;
        run_frame("post_rst", 1'b0, 4, "00101101011", -1);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmit engine: accepts a parallel word on a valid/busy handshake and serialises it into a standard asynchronous frame on `TX_out`. A frame is a start bit, then data LSB-first, then an optional parity bit, then one or two stop bits. It generalises the fixed 8-bit, one-bit-per-clock transmitter with three additions:

- configurable data width;
- an internal baud prescaler;
- selectable stop-bit count.

Each frame's configuration is latched at acceptance. It sits between the host-side register interface and the pad.

## Interface
- `DATA_WIDTH`, 8: data bits per frame; legal range 5..9.
- `CLKS_PER_BIT`, 1: clk cycles per serial bit; ≥1. A value of 1 reproduces the one-bit-per-clock rate.
- `clk`  in  1  single system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `p_data`  in  DATA_WIDTH  word to transmit; sampled only at acceptance.
- `data_valid`  in  1  word-present request; level-sensitive.
- `par_en`  in  1  1 = append parity bit; latched at acceptance.
- `par_typ`  in  1  0 = even, 1 = odd; latched at acceptance.
- `stop2`  in  1  0 = one stop bit, 1 = two stop bits; latched at acceptance.
- `TX_out`  out  1  serial line; registered; idles high.
- `busy`  out  1  frame in progress; `= (state != IDLE)`.
- `done`  out  1  one-cycle pulse on the edge that returns to IDLE.

## Operation
- **States:** IDLE, START, DATA, PARITY, STOP.
- **Acceptance:**
  - Occurs at a rising edge where state==IDLE and `data_valid`==1.
  - At that edge, latch `p_data`, `par_en`, `par_typ` and `stop2`.
  - At that edge, compute the parity bit: `^p_data ^ par_typ`.
  - Go to START with `TX_out`<=0, bit counter<=0 and prescale counter<=0.
- **`data_valid` outside IDLE:** ignored. A word held high across a frame is not double-sent, because acceptance requires IDLE.
- **Bit timing:** each state holds `TX_out` constant for exactly `CLKS_PER_BIT` cycles. The prescale counter counts 0..`CLKS_PER_BIT`-1, and the bit ends at the terminal count.
- **Transitions:**
  - START → DATA.
  - DATA emits bit[i] for i = 0..`DATA_WIDTH`-1. Leave DATA after bit `DATA_WIDTH`-1: go to PARITY if latched `par_en`, else to STOP.
  - PARITY → STOP.
  - STOP emits 1 for one bit, or for two bits if latched `stop2`, then goes to IDLE.
- **End of frame:**
  - On the edge entering IDLE, `done` is 1 for one cycle and `busy` drops.
  - If `data_valid` is 1 in the IDLE cycle, the next word is accepted on the following edge. The minimum inter-frame gap is therefore 1 clk of idle-high.
- **Frame length:** `CLKS_PER_BIT`×(1 + `DATA_WIDTH` + `par_en` + 1 + `stop2`) cycles, measured from acceptance edge to IDLE edge.
- **Counter widths:**
  - Prescale counter: `$clog2(CLKS_PER_BIT)`, minimum 1 bit.
  - Bit counter: `$clog2(DATA_WIDTH)`, also used for the stop-bit count.
- **Configuration changes mid-frame:** changing `par_en`, `par_typ`, `stop2` or `p_data` has no effect on the current frame.
- **Reset mid-frame:** the frame is aborted immediately, without waiting for a clock edge. `TX_out`=1, `busy`=0, `done`=0, state=IDLE, all counters and latched data cleared. There is no partial-frame recovery.

## Timing
- **Reset values:** `TX_out`=1, `busy`=0, `done`=0.
- **Latency:** `TX_out` falls at the acceptance edge, i.e. 0 cycles after the edge that sampled `data_valid`. `busy` rises at the same edge.
- **Bit boundaries:** every `TX_out` change aligns with a prescale terminal-count edge. There are no glitches, since `TX_out` comes straight from a flop.
- **`done`:** coincides with the edge where `busy` falls, and is never asserted outside that single cycle.
- **Reset release:** deassertion is synchronised by the surrounding reset tree. The block itself needs only IDLE behaviour on the first edge after release.

## Structure
- **Package `uart_tx_pkg`:**
  - state enum `tx_state_t` {IDLE, START, DATA, PARITY, STOP};
  - constants `PAR_EVEN`=0 and `PAR_ODD`=1;
  - constants `IDLE_LEVEL`=1 and `START_LEVEL`=0.
- **Sub-module `uart_baud_tick`:**
  - parametrised by `CLKS_PER_BIT`;
  - `clear` input, restarted at acceptance;
  - `tick` output, asserted on the terminal count;
  - when `CLKS_PER_BIT`=1, `tick` is constantly 1 while enabled.
- Parity is computed inline; no separate module.

## Test plan
- **Even parity, one stop bit.** `DATA_WIDTH`=8, `CLKS_PER_BIT`=4. Send 0xA5 with `par_en`=1, `par_typ`=0, `stop2`=0. Required: `TX_out` sequence 0,1,0,1,0,0,1,0,1,0,1, each bit held 4 clk; 44 cycles total; `done` pulses once.
- **Odd parity, two stop bits.** Send 0x00 with `par_en`=1, `par_typ`=1, `stop2`=1. Required: parity bit = 1, followed by two stop bits of 1; 12 bits × 4 = 48 cycles.
- **One bit per clock, no parity.** `CLKS_PER_BIT`=1, `DATA_WIDTH`=7. Send 0x7F with `par_en`=0. Required: 0,1,1,1,1,1,1,1,1 on consecutive clk; `busy` high for exactly 9 cycles.
- **Back-to-back frames.** Hold `data_valid`=1 with 0x3C then 0xC3. Required: second start bit begins exactly 1 idle-high clk after the first `done`. No word is duplicated or dropped.
- **Mid-frame config change.** Toggle `par_en`, `par_typ`, `stop2` and `p_data` during DATA. Required: the frame matches the values latched at acceptance.
- **Reset mid-frame.** Assert `rst`=0 during the third data bit, between clock edges. Required: `TX_out`=1 and `busy`=0 before the next edge. After release, the next valid word is transmitted correctly.
